// File: rtl/hdg_pkg.sv
// Shared types, gains and helpers for the heading controller.
// Imported by heading_pid and hdg_dterm.
package hdg_pkg;

  localparam logic signed [3:0] P_COEFF = 4'sh3;
  localparam logic signed [4:0] D_COEFF = 5'sh0E;
  localparam int D_QUEUE_DEPTH = 2;

  typedef logic signed [11:0] hdg_t;
  typedef logic signed [10:0] spd_t;

  typedef struct packed {
    logic signed [9:0] err;
    logic              vld;
  } s1_t;

  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] value,
    input int                 width
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi)
      return hi;
    else if (value < lo)
      return lo;
    else
      return value;
  endfunction

endpackage

// File: rtl/hdg_dterm.sv
// Derivative term: error history queue, clipped difference, gain.
// History only advances on valid heading samples.
module hdg_dterm
  import hdg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic signed [9:0] err,
  output logic signed [11:0] d
);

  logic signed [9:0]  q [D_QUEUE_DEPTH];
  logic signed [10:0] diff;
  logic signed [6:0]  diff7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++)
        q[i] <= '0;
    end else if (vld) begin
      q[0] <= err;
      for (int i = 1; i < D_QUEUE_DEPTH; i++)
        q[i] <= q[i-1];
    end
  end

  assign diff  = 11'(err) - 11'(q[D_QUEUE_DEPTH-1]);
  assign diff7 = 7'(sat_signed(int'(diff), 7));
  assign d     = 12'(diff7) * 12'(D_COEFF);

endmodule

// File: rtl/heading_pid.sv
// Heading PID: error stage, integrator, P/I/D sum and
// differential mix with forward speed into motor drives.
module heading_pid
  import hdg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       moving,
  input  logic       hdg_vld,
  input  hdg_t       dsrd_hdg,
  input  hdg_t       actl_hdg,
  input  logic [9:0] frwrd,
  output spd_t       lft_spd,
  output spd_t       rght_spd
);

  hdg_t               err;
  s1_t                s1_q;
  logic signed [15:0] integ;
  logic signed [15:0] isum;
  logic               ovf;
  logic signed [13:0] p;
  logic signed [9:0]  i_term;
  logic signed [11:0] d;
  logic signed [13:0] pid;
  spd_t               adj;
  logic signed [11:0] lsum;
  logic signed [11:0] rsum;

  // 12b wrap makes 180-degree crossings come out as short errors
  assign err = actl_hdg - dsrd_hdg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.err <= 10'(sat_signed(int'(err), 10));
      s1_q.vld <= hdg_vld;
    end
  end

  assign isum = integ + 16'(s1_q.err);
  assign ovf  = (integ[15] == s1_q.err[9]) &&
                (isum[15] != integ[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      integ <= '0;
    else if (!moving)
      integ <= '0;
    else if (s1_q.vld && !ovf)
      integ <= isum;
  end

  hdg_dterm u_dterm (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (s1_q.vld),
    .err   (s1_q.err),
    .d     (d)
  );

  assign p      = 14'(s1_q.err) * 14'(P_COEFF);
  assign i_term = integ[15:6];
  assign pid    = p + 14'(i_term) + 14'(d);
  assign adj    = pid[13:3];

  assign lsum = $signed({2'b00, frwrd}) + 12'(adj);
  assign rsum = $signed({2'b00, frwrd}) - 12'(adj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
    end else if (moving) begin
      lft_spd  <= 11'(sat_signed(int'(lsum), 11));
      rght_spd <= 11'(sat_signed(int'(rsum), 11));
    end else begin
      lft_spd  <= '0;
      rght_spd <= '0;
    end
  end

endmodule

// File: tb/tb_heading_pid.sv
// Directed bench for heading_pid.
// Expected drives are hand-computed from the PID equations.
module tb_heading_pid;

  logic               clk;
  logic               rst_n;
  logic               moving;
  logic               hdg_vld;
  logic signed [11:0] dsrd_hdg;
  logic signed [11:0] actl_hdg;
  logic [9:0]         frwrd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;

  int n_run;
  int n_fail;

  heading_pid dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .hdg_vld  (hdg_vld),
    .dsrd_hdg (dsrd_hdg),
    .actl_hdg (actl_hdg),
    .frwrd    (frwrd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int l, input int r);
    check({tag, "_lft"}, int'(lft_spd), l);
    check({tag, "_rght"}, int'(rght_spd), r);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one hdg_vld pulse; returns at the negedge where that sample's output is visible
  task automatic sample(input logic signed [11:0] a);
    actl_hdg = a;
    hdg_vld  = 1'b1;
    @(negedge clk);
    hdg_vld  = 1'b0;
    @(negedge clk);
  endtask

  logic signed [11:0] d_err [4];
  int d_lft [4];
  int d_rgt [4];

  initial begin
    n_run  = 0;
    n_fail = 0;
    d_err = '{12'sd0, 12'sd8, 12'sd8, 12'sd8};
    d_lft = '{256, 273, 273, 259};
    d_rgt = '{256, 239, 239, 253};

    rst_n    = 1'b0;
    moving   = 1'b0;
    hdg_vld  = 1'b0;
    dsrd_hdg = '0;
    actl_hdg = '0;
    frwrd    = '0;
    wait_cyc(2);
    check_out("reset", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // step response
    frwrd  = 10'h100;
    moving = 1'b1;
    sample(12'h010);
    check_out("step", 290, 222);
    wait_cyc(3);
    check_out("step_hold", 290, 222);

    // asynchronous reset while driving
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    dsrd_hdg = 12'h010;
    actl_hdg = 12'h000;
    wait_cyc(2);
    check_out("neg_err", 222, 290);

    frwrd    = 10'h000;
    actl_hdg = 12'h7F0;
    dsrd_hdg = 12'h010;
    wait_cyc(2);
    check_out("sat_pos", 301, -301);

    actl_hdg = 12'h810;
    dsrd_hdg = 12'h010;
    wait_cyc(2);
    check_out("sat_neg", -304, 304);

    actl_hdg = 12'h800;
    dsrd_hdg = 12'h7F0;
    wait_cyc(2);
    check_out("wrap", 34, -34);

    actl_hdg = 12'h010;
    dsrd_hdg = 12'h000;
    frwrd    = 10'h3FF;
    wait_cyc(2);
    check_out("clamp", 1023, 989);

    // derivative history
    frwrd    = 10'h100;
    dsrd_hdg = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(d_err[i]);
      check_out($sformatf("dhist%0d", i), d_lft[i], d_rgt[i]);
    end

    // integrator ramp with back-to-back samples
    do_reset();
    actl_hdg = 12'h1FF;
    hdg_vld  = 1'b1;
    wait_cyc(8);
    hdg_vld  = 1'b0;
    wait_cyc(4);
    check_out("integ8", 455, 57);
    hdg_vld  = 1'b1;
    wait_cyc(192);
    hdg_vld  = 1'b0;
    wait_cyc(4);
    check_out("integ_sat", 511, 1);

    #2 rst_n = 1'b0;
    #1 check_out("rst_integ", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);
    check_out("post_rst", 557, -45);

    hdg_vld = 1'b1;
    wait_cyc(200);
    hdg_vld = 1'b0;
    wait_cyc(4);
    check_out("integ_sat2", 511, 1);

    moving = 1'b0;
    @(negedge clk);
    check_out("stop", 0, 0);
    moving = 1'b1;
    @(negedge clk);
    check_out("restart", 447, 65);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
